// File: rtl/ip4_rtl_spa_seq_if.sv
// Instruction-request and issue-beat bundle between ISE, sequencer and SPA.
// The sequencer uses the master view; the ISE/SPA environment uses the slave view.
interface ip4_rtl_spa_seq_if #(
  parameter int NUM_FU   = 3,
  parameter int NUM_SP   = 8,
  parameter int SUBVEC_W = 2,
  parameter int TID_W    = 3
);
  logic                req_vld;
  logic                req_rdy;
  logic [TID_W-1:0]    req_tid;
  logic [SUBVEC_W-1:0] req_vec;
  logic [NUM_FU-1:0]   req_fuEn;
  logic [NUM_SP-1:0]   req_emsk;
  logic                stall;
  logic                iss_vld;
  logic [TID_W-1:0]    iss_tid;
  logic [SUBVEC_W-1:0] iss_subVec;
  logic [NUM_FU-1:0]   iss_fuEn;
  logic [NUM_SP-1:0]   iss_emsk;
  logic                iss_last;

  modport master (
    input  req_vld, req_tid, req_vec, req_fuEn, req_emsk, stall,
    output req_rdy, iss_vld, iss_tid, iss_subVec, iss_fuEn, iss_emsk, iss_last
  );

  modport slave (
    output req_vld, req_tid, req_vec, req_fuEn, req_emsk, stall,
    input  req_rdy, iss_vld, iss_tid, iss_subVec, iss_fuEn, iss_emsk, iss_last
  );
endinterface

// File: rtl/ip4_rtl_spa_seq.sv
// Sub-vector issue sequencer: expands one vector instruction into per-sub-vector beats.
// Define IP4_SPA_SEQ_EXP_EN to build the in-flight tracker and exception abort logic.
module ip4_rtl_spa_seq #(
  parameter int NUM_FU   = 3,
  parameter int NUM_SP   = 8,
  parameter int SUBVEC_W = 2,
  parameter int TID_W    = 3,
  parameter int EXE_LAT  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ip4_rtl_spa_seq_if.master     bus,
  input  logic                  exp_vld,
  output logic                  abort,
  output logic [TID_W-1:0]      abort_tid,
  output logic [SUBVEC_W-1:0]   abort_subVec,
  output logic                  busy
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [TID_W-1:0]    tid_q;
  logic [SUBVEC_W-1:0] vec_q;
  logic [NUM_FU-1:0]   fu_q;
  logic [NUM_SP-1:0]   emsk_q;
  logic [SUBVEC_W-1:0] cnt_q, cnt_d;
  logic                load;

  logic issuing, last, fire, rdy, accept;
  logic exp_hit;
  logic kill;

  assign issuing = (state_q == ISSUE);
  assign last    = issuing & (cnt_q == vec_q);
  assign fire    = issuing & ~bus.stall;
  // An exception hit blocks a back-to-back accept even when the last beat fires.
  assign rdy     = (~issuing | (last & ~bus.stall)) & ~exp_hit;
  assign accept  = bus.req_vld & rdy;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (accept) begin
      load    = 1'b1;
      cnt_d   = '0;
      state_d = ISSUE;
    end else if (fire && last) begin
      state_d = IDLE;
    end else if (fire) begin
      cnt_d = cnt_q + SUBVEC_W'(1);
    end
    if (kill) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tid_q   <= '0;
      vec_q   <= '0;
      fu_q    <= '0;
      emsk_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        tid_q  <= bus.req_tid;
        vec_q  <= bus.req_vec;
        fu_q   <= bus.req_fuEn;
        emsk_q <= bus.req_emsk;
      end
    end
  end

  assign bus.req_rdy    = rdy;
  assign bus.iss_vld    = issuing;
  assign bus.iss_tid    = tid_q;
  assign bus.iss_subVec = cnt_q;
  assign bus.iss_fuEn   = fu_q;
  assign bus.iss_emsk   = emsk_q;
  assign bus.iss_last   = last;

`ifdef IP4_SPA_SEQ_EXP_EN
  typedef struct packed {
    logic                vld;
    logic [TID_W-1:0]    tid;
    logic [SUBVEC_W-1:0] sv;
  } entry_t;

  entry_t              trk_q [EXE_LAT];
  entry_t              tail;
  logic                any_vld;
  logic                abort_q;
  logic [TID_W-1:0]    abort_tid_q;
  logic [SUBVEC_W-1:0] abort_sv_q;

  // Tail entry lines up with the exception report for the beat issued EXE_LAT cycles ago.
  assign tail    = trk_q[EXE_LAT-1];
  assign exp_hit = exp_vld & tail.vld;
  assign kill    = exp_hit & issuing & (tid_q == tail.tid);

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < EXE_LAT; i++) any_vld |= trk_q[i].vld;
  end

  // NOTE: the tracker array is reset because its valid bits gate exceptions and busy.
  always_ff @(posedge clk) begin
    if (!rst_n || exp_hit) begin
      for (int i = 0; i < EXE_LAT; i++) trk_q[i] <= '0;
    end else begin
      trk_q[0] <= '{vld: fire, tid: tid_q, sv: cnt_q};
      for (int i = 1; i < EXE_LAT; i++) trk_q[i] <= trk_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abort_q     <= 1'b0;
      abort_tid_q <= '0;
      abort_sv_q  <= '0;
    end else begin
      abort_q <= exp_hit;
      if (exp_hit) begin
        abort_tid_q <= tail.tid;
        abort_sv_q  <= tail.sv;
      end
    end
  end

  assign abort        = abort_q;
  assign abort_tid    = abort_tid_q;
  assign abort_subVec = abort_sv_q;
  assign busy         = issuing | any_vld;
`else
  // Exceptions are not tracked in this build; exp_vld is folded away.
  assign exp_hit      = exp_vld & 1'b0;
  assign kill         = 1'b0;
  assign abort        = 1'b0;
  assign abort_tid    = '0;
  assign abort_subVec = '0;
  assign busy         = issuing;
`endif

endmodule

// File: tb/tb_ip4_rtl_spa_seq.sv
// Directed bench for ip4_rtl_spa_seq; expectations track whether IP4_SPA_SEQ_EXP_EN is set.
module tb_ip4_rtl_spa_seq;
  localparam int NUM_FU = 3, NUM_SP = 8, SUBVEC_W = 2, TID_W = 3, EXE_LAT = 3;
`ifdef IP4_SPA_SEQ_EXP_EN
  localparam bit EXP_ON = 1'b1;
`else
  localparam bit EXP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic exp_vld;
  logic abort;
  logic [TID_W-1:0] abort_tid;
  logic [SUBVEC_W-1:0] abort_subVec;
  logic busy;
  int n_tests = 0;
  int n_fail  = 0;
  int fires;

  always #5 clk = ~clk;

  ip4_rtl_spa_seq_if #(.NUM_FU(NUM_FU), .NUM_SP(NUM_SP), .SUBVEC_W(SUBVEC_W), .TID_W(TID_W)) bus ();

  ip4_rtl_spa_seq #(
    .NUM_FU(NUM_FU), .NUM_SP(NUM_SP), .SUBVEC_W(SUBVEC_W), .TID_W(TID_W), .EXE_LAT(EXE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .exp_vld(exp_vld),
    .abort(abort), .abort_tid(abort_tid), .abort_subVec(abort_subVec), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic vld, input int tid, input int vec);
    bus.req_vld  = vld;
    bus.req_tid  = TID_W'(tid);
    bus.req_vec  = SUBVEC_W'(vec);
    bus.req_fuEn = 3'b101;
    bus.req_emsk = 8'hA5;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    exp_vld = 1'b0;
    bus.stall = 1'b0;
    drive_req(1'b0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst req_rdy", bus.req_rdy, 1);
    check("rst iss_vld", bus.iss_vld, 0);
    check("rst iss_tid", bus.iss_tid, 0);
    check("rst iss_subVec", bus.iss_subVec, 0);
    check("rst iss_fuEn", bus.iss_fuEn, 0);
    check("rst iss_emsk", bus.iss_emsk, 0);
    check("rst iss_last", bus.iss_last, 0);
    check("rst abort", abort, 0);
    check("rst abort_tid", abort_tid, 0);
    check("rst abort_subVec", abort_subVec, 0);
    check("rst busy", busy, 0);

    // Single instruction tid=2 vec=3, no stall
    drive_req(1'b1, 2, 3);
    check("t1 req_rdy idle", bus.req_rdy, 1);
    tick();
    drive_req(1'b0, 0, 0);
    check("t1 fuEn", bus.iss_fuEn, 3'b101);
    check("t1 emsk", bus.iss_emsk, 8'hA5);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1 vld%0d", k), bus.iss_vld, 1);
      check($sformatf("t1 tid%0d", k), bus.iss_tid, 2);
      check($sformatf("t1 sv%0d", k), bus.iss_subVec, k);
      check($sformatf("t1 last%0d", k), bus.iss_last, (k == 3) ? 1 : 0);
      tick();
    end
    check("t1 idle vld", bus.iss_vld, 0);
    check("t1 busy +1", busy, EXP_ON);
    tick(); tick();
    check("t1 busy +3", busy, EXP_ON);
    tick();
    check("t1 busy +4", busy, 0);
    check("t1 no abort", abort, 0);

    // Back-to-back vec=1: tid 1 then tid 4
    drive_req(1'b1, 1, 1);
    tick();
    drive_req(1'b1, 4, 1);
    check("b2b 1/0 tid", bus.iss_tid, 1);
    check("b2b 1/0 sv", bus.iss_subVec, 0);
    check("b2b 1/0 rdy", bus.req_rdy, 0);
    tick();
    check("b2b 1/1 sv", bus.iss_subVec, 1);
    check("b2b 1/1 last", bus.iss_last, 1);
    check("b2b 1/1 rdy", bus.req_rdy, 1);
    tick();
    drive_req(1'b0, 0, 0);
    check("b2b 4/0 vld", bus.iss_vld, 1);
    check("b2b 4/0 tid", bus.iss_tid, 4);
    check("b2b 4/0 sv", bus.iss_subVec, 0);
    tick();
    check("b2b 4/1 tid", bus.iss_tid, 4);
    check("b2b 4/1 sv", bus.iss_subVec, 1);
    check("b2b 4/1 rdy", bus.req_rdy, 1);
    tick();
    check("b2b done", bus.iss_vld, 0);
    tick(); tick(); tick();

    // Stall two cycles on subVec 1 of vec=2
    fires = 0;
    drive_req(1'b1, 3, 2);
    tick();
    drive_req(1'b0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      bus.stall = (k == 1 || k == 2);
      #1;
      check($sformatf("stl sv c%0d", k), bus.iss_subVec, (k == 0) ? 0 : (k == 4) ? 2 : 1);
      check($sformatf("stl vld c%0d", k), bus.iss_vld, 1);
      if (bus.iss_vld && !bus.stall) fires++;
      tick();
    end
    bus.stall = 1'b0;
    check("stl fires", fires, 3);
    check("stl done", bus.iss_vld, 0);
    tick(); tick(); tick();

    // Exception on subVec 0 of tid=5 vec=3, new request offered on the hit cycle
    drive_req(1'b1, 5, 3);
    tick();
    drive_req(1'b0, 0, 0);
    tick(); tick(); tick();
    check("exc sv3", bus.iss_subVec, 3);
    exp_vld = 1'b1;
    drive_req(1'b1, 7, 0);
    check("exc rdy blocked", bus.req_rdy, !EXP_ON);
    tick();
    exp_vld = 1'b0;
    drive_req(1'b0, 0, 0);
    check("exc abort", abort, EXP_ON);
    check("exc abort_tid", abort_tid, EXP_ON ? 5 : 0);
    check("exc abort_subVec", abort_subVec, 0);
    check("exc iss_vld", bus.iss_vld, !EXP_ON);
    check("exc busy", busy, !EXP_ON);
    tick();
    check("exc abort pulse", abort, 0);
    check("exc idle", bus.iss_vld, 0);
    tick(); tick(); tick();

    // Exception cuts remaining sub-vectors: tid=6 vec=3, stall on subVec 1
    drive_req(1'b1, 6, 3);
    tick();
    drive_req(1'b0, 0, 0);
    tick();
    bus.stall = 1'b1;
    tick(); tick();
    bus.stall = 1'b0;
    exp_vld = 1'b1;
    #1;
    check("cut sv1", bus.iss_subVec, 1);
    tick();
    exp_vld = 1'b0;
    #1;
    check("cut abort", abort, EXP_ON);
    check("cut abort_tid", abort_tid, EXP_ON ? 6 : 0);
    check("cut abort_subVec", abort_subVec, 0);
    check("cut iss_vld", bus.iss_vld, !EXP_ON);
    check("cut busy", busy, !EXP_ON);
    tick();
    check("cut iss_vld +1", bus.iss_vld, !EXP_ON);
    tick();
    check("cut iss_vld +2", bus.iss_vld, 0);
    tick(); tick(); tick();

    // exp_vld with nothing in flight
    exp_vld = 1'b1;
    tick();
    exp_vld = 1'b0;
    #1;
    check("spur idle abort", abort, 0);
    drive_req(1'b1, 2, 1);
    tick();
    drive_req(1'b0, 0, 0);
    exp_vld = 1'b1;
    #1;
    check("spur rdy", bus.req_rdy, 0);
    tick();
    exp_vld = 1'b0;
    #1;
    check("spur abort", abort, 0);
    check("spur iss_vld", bus.iss_vld, 1);
    check("spur sv", bus.iss_subVec, 1);
    tick(); tick(); tick(); tick();

    // Reset in the middle of an instruction
    drive_req(1'b1, 3, 3);
    tick();
    drive_req(1'b0, 0, 0);
    tick(); tick();
    check("mid sv2", bus.iss_subVec, 2);
    rst_n = 1'b0;
    tick();
    check("mid rst vld", bus.iss_vld, 0);
    check("mid rst rdy", bus.req_rdy, 1);
    check("mid rst busy", busy, 0);
    check("mid rst abort", abort, 0);
    check("mid rst sv", bus.iss_subVec, 0);
    check("mid rst tid", bus.iss_tid, 0);
    rst_n = 1'b1;
    tick();
    check("post rst busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
